// File: rtl/vproc_pkg.sv
// Shared scheduler types for the vproc stream blocks.
package vproc_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vproc_rr_pick.sv
// Round-robin pick: the first set bit of valid_i scanning from prio_i upward, modulo N.
module vproc_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] prio_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = prio_i;
    for (int i = 0; i < N; i++) begin
      int c;
      c = int'(prio_i) + i;
      if (c >= N) c = c - N;
      if (!found_o && valid_i[c]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/vproc_stream_arbiter.sv
// Round-robin N:1 stream arbiter with packet locking and source tagging.
// Define VPROC_STREAM_ARBITER_OUT_REG_EN to add a 2-entry output skid buffer.
module vproc_stream_arbiter
  import vproc_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 32,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        async_rst_ni,
  input  logic                        sync_rst_ni,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]            req_last_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [WIDTH-1:0]            out_data_o,
  output logic                        out_last_o,
  output logic [SRC_W-1:0]            out_src_o,
  output logic                        busy_o
);

  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] prio_q, prio_d, lock_q, lock_d;
  logic             found;
  logic [SRC_W-1:0] pick_idx, gnt;
  logic             core_valid, core_ready, core_last, xfer;
  logic [WIDTH-1:0] core_data;
  logic [SRC_W-1:0] core_src;

  vproc_rr_pick #(.N(N_REQ), .IDX_W(SRC_W)) u_pick (
    .valid_i (req_valid_i),
    .prio_i  (prio_q),
    .found_o (found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q <= ARB_IDLE;
      prio_q  <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    lock_d  = lock_q;
    if (!sync_rst_ni) begin
      state_d = ARB_IDLE;
      prio_d  = '0;
      lock_d  = '0;
    end else if (xfer) begin
      if (core_last) begin
        state_d = ARB_IDLE;
        prio_d  = (int'(gnt) == N_REQ - 1) ? '0 : gnt + SRC_W'(1);
      end else begin
        state_d = ARB_LOCKED;
        lock_d  = gnt;
      end
    end
  end

  // When idle with nothing valid, gnt falls back to prio_q, which is what out_src reports.
  always_comb begin
    gnt         = (state_q == ARB_LOCKED) ? lock_q : pick_idx;
    core_valid  = (state_q == ARB_LOCKED) ? req_valid_i[lock_q] : found;
    core_src    = gnt;
    core_data   = core_valid ? req_data_i[gnt] : '0;
    core_last   = core_valid & req_last_i[gnt];
    req_ready_o = '0;
    if (core_valid) req_ready_o[gnt] = core_ready;
  end

  assign xfer   = core_valid & core_ready;
  assign busy_o = (state_q == ARB_LOCKED);

`ifdef VPROC_STREAM_ARBITER_OUT_REG_EN
  typedef struct packed {
    logic             last;
    logic [SRC_W-1:0] src;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t [1:0] skid_q, skid_d;
  logic  [1:0] cnt_q, cnt_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        pop;

  // Ready toward the arbiter depends only on occupancy, cutting the out_ready_i path.
  assign core_ready = (cnt_q != 2'd2);
  assign pop        = (cnt_q != 2'd0) & out_ready_i;

  always_comb begin
    skid_d = skid_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    if (xfer) begin
      skid_d[wr_q] = '{last: core_last, src: core_src, data: core_data};
      wr_d         = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, xfer} - {1'b0, pop};
    if (!sync_rst_ni) begin
      cnt_d = '0;
      rd_d  = 1'b0;
      wr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      skid_q <= '0;
      cnt_q  <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = skid_q[rd_q].data;
  assign out_last_o  = skid_q[rd_q].last;
  assign out_src_o   = skid_q[rd_q].src;
`else
  assign core_ready  = out_ready_i;
  assign out_valid_o = core_valid;
  assign out_data_o  = core_data;
  assign out_last_o  = core_last;
  assign out_src_o   = core_src;
`endif

endmodule
